// File: rtl/lfsr_victim_sel.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_victim_sel
//  Description : Cache replacement-way selector. Picks the lowest invalid,
//                unlocked way if one exists; otherwise walks from an LFSR-
//                derived start index to the first unlocked way. One request
//                per cycle, registered response one cycle later.
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr_victim_sel #(
    parameter int          WAYS       = 4,
    parameter int          LFSR_WIDTH = 8,
    parameter int unsigned SEED       = 1,
    localparam int         IDXW       = $clog2(WAYS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic [WAYS-1:0]       valid_mask,
    input  logic [WAYS-1:0]       lock_mask,
    input  logic                  seed_we,
    input  logic [LFSR_WIDTH-1:0] seed,
    output logic                  resp_valid,
    output logic                  resp_none,
    output logic [IDXW-1:0]       victim_idx,
    output logic [WAYS-1:0]       victim_onehot,
    output logic [LFSR_WIDTH-1:0] lfsr_state
);

    // Maximal-length feedback taps, bit n set means state bit n feeds the XOR.
    function automatic logic [31:0] taps_for(input int w);
        case (w)
            3:       taps_for = 32'h0000_0006;
            4:       taps_for = 32'h0000_0009;
            5:       taps_for = 32'h0000_0014;
            6:       taps_for = 32'h0000_0030;
            7:       taps_for = 32'h0000_0060;
            8:       taps_for = 32'h0000_008E;
            9:       taps_for = 32'h0000_0110;
            10:      taps_for = 32'h0000_0240;
            11:      taps_for = 32'h0000_0500;
            12:      taps_for = 32'h0000_0829;
            13:      taps_for = 32'h0000_100D;
            14:      taps_for = 32'h0000_2015;
            15:      taps_for = 32'h0000_6000;
            16:      taps_for = 32'h0000_8016;
            17:      taps_for = 32'h0001_2000;
            18:      taps_for = 32'h0002_0400;
            19:      taps_for = 32'h0004_0023;
            20:      taps_for = 32'h0009_0000;
            21:      taps_for = 32'h0014_0000;
            22:      taps_for = 32'h0030_0000;
            23:      taps_for = 32'h0042_0000;
            24:      taps_for = 32'h00E1_0000;
            25:      taps_for = 32'h0120_0000;
            26:      taps_for = 32'h0200_0023;
            27:      taps_for = 32'h0400_0013;
            28:      taps_for = 32'h0900_0000;
            29:      taps_for = 32'h1400_0000;
            30:      taps_for = 32'h2000_0029;
            31:      taps_for = 32'h4800_0000;
            32:      taps_for = 32'h8000_0062;
            default: taps_for = 32'h0000_0000;
        endcase
    endfunction

    localparam logic [31:0]           TAPS_ALL   = taps_for(LFSR_WIDTH);
    localparam logic [LFSR_WIDTH-1:0] TAPS       = TAPS_ALL[LFSR_WIDTH-1:0];
    localparam logic [LFSR_WIDTH-1:0] SEED_TRUNC = SEED[LFSR_WIDTH-1:0];
    // The all-zero state would lock the LFSR, so a zero seed becomes 1.
    localparam logic [LFSR_WIDTH-1:0] SEED_INIT  =
        (SEED_TRUNC == '0) ? LFSR_WIDTH'(1) : SEED_TRUNC;

    logic [LFSR_WIDTH-1:0] lfsr;
    logic [LFSR_WIDTH-1:0] lfsr_next;
    logic [LFSR_WIDTH-1:0] seed_safe;

    logic [WAYS-1:0]       free_ways;
    logic                  free_found;
    logic [IDXW-1:0]       free_idx;
    logic                  rot_found;
    logic [IDXW-1:0]       rot_idx;
    logic [IDXW-1:0]       rot_start;
    logic [IDXW-1:0]       rot_cand;

    logic                  sel_none;
    logic [IDXW-1:0]       sel_idx;
    logic [WAYS-1:0]       sel_onehot;

    assign lfsr_next  = {lfsr[LFSR_WIDTH-2:0], ^(lfsr & TAPS)};
    assign seed_safe  = (seed == '0) ? LFSR_WIDTH'(1) : seed;
    assign lfsr_state = lfsr;

    // LFSR register: reset beats reseed, reseed beats the free-running advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= SEED_INIT;
        end else if (seed_we) begin
            lfsr <= seed_safe;
        end else begin
            lfsr <= lfsr_next;
        end
    end

    assign free_ways = ~valid_mask & ~lock_mask;

    // Lowest-index invalid and unlocked way; the downward scan lets index 0 win.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (free_ways[i]) begin
                free_found = 1'b1;
                free_idx   = IDXW'(i);
            end
        end
    end

    assign rot_start = lfsr[IDXW-1:0];

    // First unlocked way walking upward from the LFSR start index, wrapping;
    // IDXW-bit addition wraps modulo WAYS because WAYS is a power of two.
    always_comb begin
        rot_found = 1'b0;
        rot_idx   = '0;
        rot_cand  = '0;
        for (int k = WAYS - 1; k >= 0; k--) begin
            rot_cand = rot_start + IDXW'(k);
            if (!lock_mask[rot_cand]) begin
                rot_found = 1'b1;
                rot_idx   = rot_cand;
            end
        end
    end

    // No unlocked way at all means no victim; a free way is always unlocked.
    assign sel_none = ~rot_found;
    assign sel_idx  = free_found ? free_idx : (rot_found ? rot_idx : '0);

    genvar g;
    generate
        for (g = 0; g < WAYS; g++) begin : g_onehot
            assign sel_onehot[g] = ~sel_none & (sel_idx == IDXW'(g));
        end
    endgenerate

    // Response registers: strobe follows every request, payload updates only on requests.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid    <= 1'b0;
            resp_none     <= 1'b0;
            victim_idx    <= '0;
            victim_onehot <= '0;
        end else begin
            resp_valid <= req_valid;
            if (req_valid) begin
                resp_none     <= sel_none;
                victim_idx    <= sel_idx;
                victim_onehot <= sel_onehot;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lfsr_victim_sel.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lfsr_victim_sel
//  Description : Self-checking bench for lfsr_victim_sel (WAYS=4, 8-bit LFSR,
//                SEED=1). Expected responses are queued when requests are
//                driven and compared when resp_valid appears.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_victim_sel;

    localparam int WAYS = 4;
    localparam int LW   = 8;

    typedef struct packed {
        logic       none;
        logic [1:0] idx;
        logic [3:0] onehot;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic [3:0]    valid_mask = '0;
    logic [3:0]    lock_mask = '0;
    logic          seed_we = 1'b0;
    logic [LW-1:0] seed = '0;
    logic          resp_valid;
    logic          resp_none;
    logic [1:0]    victim_idx;
    logic [3:0]    victim_onehot;
    logic [LW-1:0] lfsr_state;

    int   checks = 0;
    int   passed = 0;
    exp_t sb[$];

    lfsr_victim_sel #(.WAYS(WAYS), .LFSR_WIDTH(LW), .SEED(1)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .valid_mask    (valid_mask),
        .lock_mask     (lock_mask),
        .seed_we       (seed_we),
        .seed          (seed),
        .resp_valid    (resp_valid),
        .resp_none     (resp_none),
        .victim_idx    (victim_idx),
        .victim_onehot (victim_onehot),
        .lfsr_state    (lfsr_state)
    );

    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Response monitor: pops the scoreboard on every resp_valid.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (resp_valid) begin
            checks++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_resp: resp_valid=1 with no request outstanding");
            end else begin
                e = sb.pop_front();
                if ({resp_none, victim_idx, victim_onehot} !== {e.none, e.idx, e.onehot})
                    $display("FAIL resp_payload: got none=%0b idx=%0d onehot=%b, expected none=%0b idx=%0d onehot=%b",
                             resp_none, victim_idx, victim_onehot, e.none, e.idx, e.onehot);
                else
                    passed++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = 1'b0;
        seed_we   = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    function automatic exp_t mk(input logic none, input logic [1:0] idx, input logic [3:0] oh);
        exp_t e;
        e.none   = none;
        e.idx    = idx;
        e.onehot = oh;
        return e;
    endfunction

    // Drive one request for the current cycle and queue its expected response.
    task automatic issue(input logic [3:0] v, input logic [3:0] lk, input exp_t e);
        req_valid  = 1'b1;
        valid_mask = v;
        lock_mask  = lk;
        sb.push_back(e);
    endtask

    // Reference selection: invalid-first, else rotating from state[1:0].
    function automatic exp_t ref_sel(input logic [7:0] s, input logic [3:0] v, input logic [3:0] lk);
        exp_t e;
        int   r;
        int   w;
        bit   found;
        e     = mk(1'b1, 2'd0, 4'd0);
        found = 0;
        r     = int'(s) % 4;
        for (int i = 0; i < 4; i++) begin
            if (!found && v[i] == 1'b0 && lk[i] == 1'b0) begin
                found = 1;
                e.idx = 2'(i);
            end
        end
        for (int k = 0; k < 4; k++) begin
            w = (r + k) % 4;
            if (!found && lk[w] == 1'b0) begin
                found = 1;
                e.idx = 2'(w);
            end
        end
        if (found) begin
            e.none   = 1'b0;
            e.onehot = 4'b0001 << e.idx;
        end
        return e;
    endfunction

    function automatic logic [7:0] ref_adv(input logic [7:0] s);
        return {s[6:0], ^(s & 8'h8E)};
    endfunction

    task automatic test_reset();
        do_reset();
        checks++;
        if ({resp_valid, resp_none, victim_idx, victim_onehot} !== 8'h00)
            $display("FAIL reset_outputs: got valid=%0b none=%0b idx=%0d onehot=%b, expected all 0",
                     resp_valid, resp_none, victim_idx, victim_onehot);
        else passed++;
        checks++;
        if (lfsr_state !== 8'h01)
            $display("FAIL reset_lfsr: got %h expected 01", lfsr_state);
        else passed++;
    endtask

    task automatic test_free_run();
        logic [7:0] exp_seq [5];
        logic [7:0] m;
        int bad;
        int early;
        exp_seq = '{8'h01, 8'h02, 8'h05, 8'h0B, 8'h16};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (lfsr_state !== exp_seq[i])
                $display("FAIL free_run[%0d]: got %h expected %h", i, lfsr_state, exp_seq[i]);
            else passed++;
            step();
        end
        do_reset();
        m     = 8'h01;
        bad   = 0;
        early = 0;
        for (int n = 1; n <= 255; n++) begin
            step();
            m = ref_adv(m);
            if (lfsr_state == 8'h00 || lfsr_state !== m) bad++;
            if (lfsr_state == 8'h01 && n < 255) early++;
        end
        checks++;
        if (bad != 0 || early != 0 || lfsr_state !== 8'h01)
            $display("FAIL period_255: bad=%0d early_repeat=%0d final=%h expected 0/0/01", bad, early, lfsr_state);
        else passed++;
    endtask

    task automatic test_random_pick();
        do_reset();
        issue(4'hF, 4'h0, mk(1'b0, 2'd1, 4'b0010));
        step();
        issue(4'hF, 4'h0, mk(1'b0, 2'd2, 4'b0100));
        step();
        req_valid = 1'b0;
        step();
    endtask

    task automatic test_locked_skip();
        do_reset();
        issue(4'hF, 4'b0110, mk(1'b0, 2'd3, 4'b1000));
        step();
        issue(4'hF, 4'b1110, mk(1'b0, 2'd0, 4'b0001));
        step();
        issue(4'hF, 4'b1110, mk(1'b0, 2'd0, 4'b0001));
        step();
        req_valid = 1'b0;
        step();
    endtask

    task automatic test_invalid_priority();
        do_reset();
        issue(4'b1010, 4'b0000, mk(1'b0, 2'd0, 4'b0001));
        step();
        issue(4'b1010, 4'b0001, mk(1'b0, 2'd2, 4'b0100));
        step();
        issue(4'b1010, 4'hF, mk(1'b1, 2'd0, 4'b0000));
        step();
        req_valid = 1'b0;
        valid_mask = 4'hF;
        lock_mask  = 4'h0;
        step();
        step();
        checks++;
        if ({resp_valid, resp_none, victim_idx, victim_onehot} !== {1'b0, 1'b1, 2'd0, 4'd0})
            $display("FAIL hold_outputs: got valid=%0b none=%0b idx=%0d onehot=%b, expected 0/1/0/0000",
                     resp_valid, resp_none, victim_idx, victim_onehot);
        else passed++;
    endtask

    task automatic test_reseed();
        do_reset();
        seed_we = 1'b1;
        seed    = 8'h00;
        step();
        seed_we = 1'b0;
        checks++;
        if (lfsr_state !== 8'h01)
            $display("FAIL reseed_zero: got %h expected 01", lfsr_state);
        else passed++;
        repeat (4) step();
        checks++;
        if (lfsr_state !== 8'h16)
            $display("FAIL pre_reseed_state: got %h expected 16", lfsr_state);
        else passed++;
        seed_we = 1'b1;
        seed    = 8'hA5;
        issue(4'hF, 4'h0, mk(1'b0, 2'd2, 4'b0100));
        step();
        seed_we   = 1'b0;
        req_valid = 1'b0;
        checks++;
        if (lfsr_state !== 8'hA5)
            $display("FAIL reseed_load: got %h expected a5", lfsr_state);
        else passed++;
        step();
        checks++;
        if (lfsr_state !== 8'h4A)
            $display("FAIL reseed_advance: got %h expected 4a", lfsr_state);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] m;
        logic [3:0] v;
        logic [3:0] lk;
        do_reset();
        m = 8'h01;
        for (int i = 0; i < 24; i++) begin
            v  = 4'($urandom_range(0, 15));
            lk = 4'($urandom_range(0, 15));
            if (i % 3 == 0) v = 4'hF;
            issue(v, lk, ref_sel(m, v, lk));
            step();
            m = ref_adv(m);
        end
        req_valid = 1'b0;
        step();
        checks++;
        if (lfsr_state !== ref_adv(m))
            $display("FAIL b2b_lfsr_track: got %h expected %h", lfsr_state, ref_adv(m));
        else passed++;
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        issue(4'hF, 4'h0, mk(1'b0, 2'd1, 4'b0010));
        step();
        reset      = 1'b1;
        req_valid  = 1'b1;
        valid_mask = 4'h0;
        lock_mask  = 4'h0;
        step();
        checks++;
        if ({resp_valid, resp_none, victim_idx, victim_onehot} !== 8'h00 || lfsr_state !== 8'h01)
            $display("FAIL reset_mid_op: got valid=%0b none=%0b idx=%0d onehot=%b lfsr=%h, expected 0/0/0/0000/01",
                     resp_valid, resp_none, victim_idx, victim_onehot, lfsr_state);
        else passed++;
        reset     = 1'b0;
        req_valid = 1'b0;
        step();
        checks++;
        if (resp_valid !== 1'b0)
            $display("FAIL reset_drop_req: got resp_valid=%0b expected 0", resp_valid);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_random_pick();
        test_locked_skip();
        test_invalid_priority();
        test_reseed();
        test_back_to_back();
        test_reset_mid_op();
        step();
        step();
        checks++;
        if (sb.size() != 0)
            $display("FAIL scoreboard_drain: got %0d outstanding expected 0", sb.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lfsr_victim_sel.md
# lfsr_victim_sel

Parametrised replacement-way selector for the set-associative caches. It combines a free-running maximal-length LFSR with invalid-way priority and lock masking. The cache controller issues one request per miss and receives one registered victim way a cycle later. It succeeds the plain LFSR with way-count generalisation, runtime reseeding, zero-state lockup protection and locked-way skipping.

## Interface
- `WAYS`, 4: number of ways; power of two, 2..16. `IDXW = log2(WAYS)`.
- `LFSR_WIDTH`, 8: LFSR state width, 3..32; must be ≥ `IDXW`.
- `SEED`, 1: reset value of the LFSR; a value of 0 is replaced by 1.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in 1: victim request. No backpressure; every cycle with `req_valid` high is accepted.
- `valid_mask` in `WAYS`: per-way valid bits of the indexed set. Sampled with `req_valid`.
- `lock_mask` in `WAYS`: ways that must never be chosen. Sampled with `req_valid`.
- `seed_we` in 1: load a new LFSR state.
- `seed` in `LFSR_WIDTH`: value loaded when `seed_we` is high.
- `resp_valid` out 1: response strobe, exactly one pulse per request.
- `resp_none` out 1: every way is locked; no victim.
- `victim_idx` out `IDXW`: binary index of the chosen way.
- `victim_onehot` out `WAYS`: one-hot form of `victim_idx`; all zeros when `resp_none` is high.
- `lfsr_state` out `LFSR_WIDTH`: current LFSR register, for debug and verification.

## Operation
- **LFSR:** Fibonacci, shift-left: `next = {s[W-2:0], ^(s & TAPS)}`.
  - `TAPS` comes from the team maximal-length table. Examples: W=4 → 0x9, W=8 → 0x8e, W=16 → 0x8016, W=32 → 0x80000062.
  - The LFSR advances every non-reset cycle; it is free-running and independent of `req_valid`.
- **Lockup guard:** any load of 0, from `SEED` or from `seed`, stores 1 instead. The zero state is unreachable.
- **LFSR update priority:** `reset` > `seed_we` > advance.
  - When `seed_we` is high, `seed` (0 mapped to 1) is stored and that cycle's advance is dropped.
- **Selection:** combinational on the current-cycle state and masks; the result is registered.
  1. If any way has `valid_mask=0` and `lock_mask=0`, choose the lowest such index.
  2. Otherwise set `r = lfsr_state[IDXW-1:0]` and choose the first way in order r, r+1, …, wrapping mod `WAYS`, with `lock_mask=0`.
  3. If every way is locked: `resp_none=1`, `victim_onehot=0`, `victim_idx=0`.
- **Same-cycle request and reseed:** a request in a cycle with `seed_we` high uses the pre-load state.
- **Output registers:** the response registers are written only when `req_valid` is high.
  - `resp_valid` is registered `req_valid`.
  - `victim_idx`, `victim_onehot` and `resp_none` hold their last values when no request arrives.

## Timing
- **Latency:** 1 cycle. A request sampled at edge N produces `resp_valid` high during cycle N+1.
- **Throughput:** one request per cycle. Back-to-back requests see consecutive LFSR states.
- **Reset values:**
  - `lfsr_state` = `SEED` (or 1 if `SEED` is 0).
  - `resp_valid`, `resp_none`, `victim_idx` and `victim_onehot` are all 0.
- **First advance:** the first cycle after reset deasserts uses the `SEED` state, and the LFSR advances at the end of that cycle.
- **Reset mid-operation:** a request in the same cycle as `reset` is dropped, so no `resp_valid` follows it. Reset also clears a `resp_valid` already pending.

## Test plan
All scenarios use `WAYS=4`, `LFSR_WIDTH=8`, `SEED=1`.

1. **Free-run sequence:** release reset, no other stimulus → `lfsr_state` reads 0x01, 0x02, 0x05, 0x0B, 0x16 on successive cycles. Full 255-state period, never 0.
2. **Random pick:** first cycle after reset, `req_valid=1`, `valid_mask=4'hF`, `lock_mask=0` → next cycle `resp_valid=1`, `victim_idx=1`, `victim_onehot=4'b0010`. A second request the following cycle → `victim_idx=2`.
3. **Locked skip:** state 0x01, `valid_mask=4'hF`, `lock_mask=4'b0110` → `victim_idx=3`. With `lock_mask=4'b1110` → wraps to `victim_idx=0`.
4. **Invalid priority and all-locked:**
   - `valid_mask=4'b1010`, `lock_mask=0` → `victim_idx=0`.
   - `valid_mask=4'b1010`, `lock_mask=4'b0001` → `victim_idx=2`.
   - `lock_mask=4'hF` → `resp_none=1`, `victim_onehot=0`.
5. **Reseed:**
   - `seed_we=1`, `seed=8'h00` → next cycle `lfsr_state=0x01`.
   - `seed_we=1`, `seed=8'hA5` together with `req_valid` (state 0x16, all valid, none locked) → response uses 0x16, so `victim_idx=2`; following cycle `lfsr_state=0xA5`.
6. **Reset mid-operation:** `req_valid=1` in the same cycle as `reset=1` → next cycle `resp_valid=0` and all outputs at reset values.
